// File: rtl/seq_mul_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_shift_add
// Description : Sequential shift-and-add multiplier, signed/unsigned, with
//               start/done handshake and optional early termination.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_shift_add #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [2*WIDTH-1:0]   r_areg;
    logic [WIDTH-1:0]     r_breg;
    logic [2*WIDTH-1:0]   r_p;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_neg;

    logic                 w_accept;
    logic                 w_terminate;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_sum;
    logic [2*WIDTH-1:0]   w_result;

    // Most-negative operand negates to itself, which read unsigned is its magnitude.
    assign w_a_mag     = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign w_b_mag     = (signed_mode && b[WIDTH-1]) ? -b : b;
    assign w_accept    = start && (r_state != c_st_run);
    assign w_terminate = (EARLY_TERM && (r_breg == '0)) || (r_cnt == c_cnt_last);
    assign w_sum       = r_p + r_areg;
    assign w_result    = r_neg ? -r_p : r_p;

    assign busy = (r_state == c_st_run);
    assign done = (r_state == c_st_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_nxt = c_st_run;
            c_st_run:  if (w_terminate) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = start ? c_st_run : c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_areg  <= '0;
            r_breg  <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            product <= '0;
        end else if (w_accept) begin
            r_areg <= {{WIDTH{1'b0}}, w_a_mag};
            r_breg <= w_b_mag;
            r_p    <= '0;
            r_cnt  <= '0;
            r_neg  <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (r_state == c_st_run) begin
            if (w_terminate) begin
                product <= w_result;
            end else begin
                if (r_breg[0]) begin
                    r_p <= w_sum;
                end
                r_areg <= r_areg << 1;
                r_breg <= r_breg >> 1;
                r_cnt  <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire
